// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump sequencer: state encoding
// and default geometry matching the register file instance.
package regfile_dump_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump.sv
// Read-side dump sequencer for the register file. Walks a wrapping address
// range, captures each read word and presents it as an addr/data beat under
// valid/ready. Optional out_parity port when REGFILE_DUMP_PARITY_EN is defined.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
`ifdef REGFILE_DUMP_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  dump_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  // Sequencer: load range on start, capture in READ, hold beat in SEND until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_addr_q  <= start_addr;
            remaining_q <= count;
            state_q     <= (count == '0) ? DONE : READ;
          end
        end
        READ: begin
          out_data_q <= r_data;
          out_addr_q <= cur_addr_q;
          state_q    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (remaining_q == REM_ONE) begin
              state_q <= DONE;
            end else begin
              remaining_q <= remaining_q - REM_ONE;
              cur_addr_q  <= cur_addr_q + ADDR_ONE;
              state_q     <= READ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef REGFILE_DUMP_PARITY_EN
  logic parity_q;

  // Parity captured alongside out_data so it stays stable through SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (state_q == READ) begin
      parity_q <= ^r_data;
    end
  end

  assign out_parity = parity_q;
`endif

  // Status decodes come straight from the state register, so an async reset
  // clears them immediately.
  assign r_addr    = cur_addr_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump with a behavioural register file
// (combinational read) attached to r_addr/r_data.
module tb_regfile_dump;

  typedef struct packed {
    logic [2:0]       sa;
    logic [3:0]       cnt;
    logic [7:0][2:0]  ea;
    logic [7:0][7:0]  ed;
    int unsigned      stall_beat;
    int unsigned      stall_len;
    int unsigned      busy_start_cyc;
    int unsigned      done_cyc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] count;
  logic [2:0] r_addr;
  logic [7:0] r_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_addr;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
`ifdef REGFILE_DUMP_PARITY_EN
  logic       out_parity;
`endif

  logic [7:0] regs [8];
  assign r_data = regs[r_addr];

  int unsigned checks = 0;
  int unsigned errors = 0;

  regfile_dump #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
`ifdef REGFILE_DUMP_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a dump, then follow it cycle by cycle, checking every beat,
  // stall stability, done timing and the idle state after done.
  task automatic run_vec(input vec_t v);
    int unsigned cyc;
    int unsigned beat;
    int unsigned stall;
    logic        seen_done;
    start_addr = v.sa;
    count      = v.cnt;
    start      = 1'b1;
    out_ready  = 1'b1;
    tick();
    start      = 1'b0;
    start_addr = 3'd0;
    count      = 4'd0;
    cyc        = 1;
    beat       = 0;
    stall      = 0;
    seen_done  = 1'b0;
    check("busy_k_plus_1", 32'(busy), 32'd1);
    while (!seen_done && cyc < 80) begin
      if (v.busy_start_cyc == cyc) begin
        start      = 1'b1;
        start_addr = 3'd7;
        count      = 4'd8;
      end else begin
        start      = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", cyc, v.done_cyc);
        check("beat_count", beat, 32'(v.cnt));
        check("valid_at_done", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        if (beat >= 32'(v.cnt)) begin
          check("extra_beat", beat, 32'(v.cnt) - 1);
          out_ready = 1'b1;
        end else begin
          check("beat_addr", 32'(out_addr), 32'(v.ea[beat]));
          check("beat_data", 32'(out_data), 32'(v.ed[beat]));
`ifdef REGFILE_DUMP_PARITY_EN
          check("beat_parity", 32'(out_parity), 32'(^v.ed[beat]));
`endif
          if (beat == v.stall_beat && stall < v.stall_len) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
            beat++;
          end
        end
      end
      if (!seen_done) begin
        tick();
        cyc++;
      end
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  vec_t vecs [6];
  vec_t post_rst;

  initial begin
    // {sa, cnt, ea[7..0], ed[7..0], stall_beat, stall_len, busy_start_cyc, done_cyc}
    vecs[0] = '{3'd0, 4'd8,
                {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                {8'h38, 8'hF0, 8'h0F, 8'h08, 8'h4B, 8'h03, 8'h03, 8'h45},
                0, 0, 0, 17};
    vecs[1] = '{3'd6, 4'd4,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd7, 3'd6},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h45, 8'h38, 8'hF0},
                0, 0, 0, 9};
    vecs[2] = '{3'd2, 4'd3,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3, 3'd2},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h4B, 8'h03},
                1, 5, 0, 12};
    vecs[3] = '{3'd5, 4'd1,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F},
                0, 0, 0, 3};
    vecs[4] = '{3'd3, 4'd0, '0, '0, 0, 0, 0, 1};
    vecs[5] = '{3'd1, 4'd3,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h4B, 8'h03, 8'h03},
                0, 0, 3, 7};
    post_rst = '{3'd4, 4'd2,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd4},
                {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h08},
                0, 0, 0, 5};

    regs       = '{8'h45, 8'h03, 8'h03, 8'h4B, 8'h08, 8'h0F, 8'hF0, 8'h38};
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = 3'd0;
    count      = 4'd0;
    out_ready  = 1'b1;

    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_r_addr", 32'(r_addr), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
`ifdef REGFILE_DUMP_PARITY_EN
    check("rst_parity", 32'(out_parity), 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Consecutive vectors also exercise start in the cycle after done.
    for (int unsigned i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Reset between clock edges while a beat is pending in SEND.
    start_addr = 3'd2;
    count      = 4'd4;
    start      = 1'b1;
    out_ready  = 1'b0;
    tick();
    start = 1'b0;
    for (int unsigned w = 0; w < 10 && !out_valid; w++) tick();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_r_addr", 32'(r_addr), 32'd0);
    tick();
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_rst_done", 32'(done), 32'd0);
    run_vec(post_rst);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
